// File: rtl/key_proto_pkg.sv
// Key-command protocol constants shared by the encoder (TX) and decoder (RX) sides.
// One ASCII byte per key level change: lowercase = press, uppercase = release.
package key_proto_pkg;

  localparam int unsigned NUM_KEYS = 10;
  localparam int unsigned IDX_W    = 4;

  typedef logic [7:0]       byte_t;
  typedef logic [IDX_W-1:0] key_idx_t;

  localparam key_idx_t KeyP1Up    = 4'd0;
  localparam key_idx_t KeyP1Down  = 4'd1;
  localparam key_idx_t KeyP1Left  = 4'd2;
  localparam key_idx_t KeyP1Right = 4'd3;
  localparam key_idx_t KeyP1Fire  = 4'd4;
  localparam key_idx_t KeyP2Up    = 4'd5;
  localparam key_idx_t KeyP2Down  = 4'd6;
  localparam key_idx_t KeyP2Left  = 4'd7;
  localparam key_idx_t KeyP2Right = 4'd8;
  localparam key_idx_t KeyP2Fire  = 4'd9;

  //                                      w      s      a      d      j
  //                                      i      k      h      l      n
  localparam byte_t PRESS_CHAR [NUM_KEYS] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h6A,
                                              8'h69, 8'h6B, 8'h68, 8'h6C, 8'h6E};
  localparam byte_t RELEASE_CHAR [NUM_KEYS] = '{8'h57, 8'h53, 8'h41, 8'h44, 8'h4A,
                                                8'h49, 8'h4B, 8'h48, 8'h4C, 8'h4E};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } enc_state_e;

  // Out-of-range indices map to 8'h00 so a corrupt index never emits a valid command.
  function automatic byte_t key_char(input key_idx_t idx, input logic pressed);
    byte_t c;
    c = 8'h00;
    if (idx < 4'(NUM_KEYS)) begin
      c = pressed ? PRESS_CHAR[idx] : RELEASE_CHAR[idx];
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_key_encoder_if.sv
// Valid/ready byte stream between the key encoder and a UART transmitter.
interface uart_key_encoder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/key_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending at or after rr_ptr, wrapping 9 -> 0.
module key_rr_arbiter
  import key_proto_pkg::*;
(
  input  logic [NUM_KEYS-1:0] pending,
  input  key_idx_t            rr_ptr,
  output key_idx_t            idx,
  output logic                any
);

  logic       found;
  logic [4:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cand = {1'b0, rr_ptr} + 5'(k);
      if (cand >= 5'(NUM_KEYS)) begin
        cand = cand - 5'(NUM_KEYS);
      end
      if (!found && pending[cand[3:0]]) begin
        found = 1'b1;
        idx   = cand[3:0];
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/uart_key_encoder.sv
// Samples ten key levels and streams one ASCII byte per level change (press/release),
// plus a periodic full-state re-announce, over a valid/ready byte interface.
module uart_key_encoder
  import key_proto_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  uart_key_encoder_if.master  tx
);

  localparam logic        RefreshEn   = (REFRESH_CYCLES != 0);
  localparam logic [31:0] RefreshLast = 32'(REFRESH_CYCLES) - 32'd1;

  enc_state_e state_q, state_d;

  logic [NUM_KEYS-1:0] meta_q, lvl_q;
  logic [NUM_KEYS-1:0] sent_state_q, sent_state_d;
  logic [NUM_KEYS-1:0] refresh_mask_q, refresh_mask_d;
  key_idx_t            rr_ptr_q, rr_ptr_d;
  key_idx_t            idx_q, idx_d;
  logic                snd_lvl_q, snd_lvl_d;
  byte_t               data_q, data_d;
  logic                valid_q, valid_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [NUM_KEYS-1:0] pending;
  key_idx_t            arb_idx;
  logic                arb_any;
  logic                wrap;

  assign pending = (lvl_q ^ sent_state_q) | refresh_mask_q;

  key_rr_arbiter u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr_q),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    wrap  = RefreshEn && (cnt_q == RefreshLast);
    cnt_d = '0;
    if (RefreshEn && !wrap) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // IDLE latches the pick, LOAD registers the byte, SEND holds it until accepted.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snd_lvl_d      = snd_lvl_q;
    data_d         = data_q;
    valid_d        = valid_q;
    sent_state_d   = sent_state_q;
    refresh_mask_d = refresh_mask_q;
    rr_ptr_d       = rr_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          idx_d     = arb_idx;
          snd_lvl_d = lvl_q[arb_idx];
          state_d   = StLoad;
        end
      end
      StLoad: begin
        data_d  = key_char(idx_q, snd_lvl_q);
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (tx.tx_ready) begin
          sent_state_d[idx_q]   = snd_lvl_q;
          refresh_mask_d[idx_q] = 1'b0;
          rr_ptr_d              = (idx_q == 4'(NUM_KEYS - 1)) ? 4'd0 : idx_q + 4'd1;
          valid_d               = 1'b0;
          state_d               = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A refresh set overrides a handshake clear in the same cycle.
    if (wrap) begin
      refresh_mask_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      meta_q         <= '0;
      lvl_q          <= '0;
      sent_state_q   <= '0;
      refresh_mask_q <= '0;
      rr_ptr_q       <= '0;
      idx_q          <= '0;
      snd_lvl_q      <= 1'b0;
      data_q         <= 8'h00;
      valid_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      meta_q         <= key_level;
      lvl_q          <= meta_q;
      sent_state_q   <= sent_state_d;
      refresh_mask_q <= refresh_mask_d;
      rr_ptr_q       <= rr_ptr_d;
      idx_q          <= idx_d;
      snd_lvl_q      <= snd_lvl_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      cnt_q          <= cnt_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

endmodule

// File: tb/tb_uart_key_encoder.sv
// Directed bench for uart_key_encoder: one instance without refresh for the
// change-driven tests, one with a 100-cycle refresh period.
module tb_uart_key_encoder;
  import key_proto_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_r;
  logic [9:0] keys;
  logic [9:0] keys_r;

  always #5 clk = ~clk;

  uart_key_encoder_if tx_if ();
  uart_key_encoder_if txr_if ();

  uart_key_encoder #(.REFRESH_CYCLES(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_level (keys),
    .tx        (tx_if)
  );

  uart_key_encoder #(.REFRESH_CYCLES(100)) dut_ref (
    .clk       (clk),
    .rst       (rst_r),
    .key_level (keys_r),
    .tx        (txr_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] got[$];
  logic [7:0] got_r[$];
  int         got_r_cyc[$];

  always @(posedge clk) cyc++;

  // Handshake is visible half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
    if (txr_if.tx_valid && txr_if.tx_ready) begin
      got_r.push_back(txr_if.tx_data);
      got_r_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int b;
    b = budget;
    while (got.size() < n && b > 0) begin
      tick(1);
      b--;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tx_if.tx_valid && n < 20) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(tx_if.tx_valid), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] q[$], input string exp);
    check_eq({tag, "_len"}, q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < q.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int lat;
    logic stable;
    int l_cyc;

    keys             = '0;
    keys_r           = '0;
    rst              = 1'b1;
    rst_r            = 1'b1;
    tx_if.tx_ready   = 1'b0;
    txr_if.tx_ready  = 1'b1;
    tick(2);
    check_eq("reset_valid", 32'(tx_if.tx_valid), 32'd0);
    check_eq("reset_data", 32'(tx_if.tx_data), 32'h00);
    rst            = 1'b0;
    rst_r          = 1'b0;
    tx_if.tx_ready = 1'b1;
    tick(3);
    check_eq("idle_valid", 32'(tx_if.tx_valid), 32'd0);

    // Press / release p1_up with latency measurement
    keys = 10'h001;
    lat  = 0;
    do begin
      tick(1);
      lat++;
    end while (!tx_if.tx_valid && lat < 20);
    check_eq("latency", lat, 4);
    check_eq("first_data", 32'(tx_if.tx_data), 32'h77);
    wait_bytes(1, 20);
    keys = 10'h000;
    wait_bytes(2, 20);
    check_seq("press_release", got, "wW");
    got.delete();

    // Backpressure on p2_fire
    tx_if.tx_ready = 1'b0;
    keys           = 10'h200;
    wait_valid("bp_valid");
    check_eq("bp_data", 32'(tx_if.tx_data), 32'h6E);
    stable = 1'b1;
    repeat (20) begin
      tick(1);
      if (!tx_if.tx_valid || tx_if.tx_data !== 8'h6E) stable = 1'b0;
    end
    check_eq("bp_stable", 32'(stable), 32'd1);
    check_eq("bp_none", got.size(), 0);
    tx_if.tx_ready = 1'b1;
    tick(6);
    check_seq("bp_one", got, "n");
    got.delete();
    keys = 10'h000;
    wait_bytes(1, 20);
    tick(4);
    check_seq("bp_release", got, "N");
    got.delete();

    // All ten keys at once, then all released; rr_ptr is back at 0 both times
    keys = 10'h3FF;
    wait_bytes(10, 100);
    tick(4);
    check_seq("rr_press", got, "wsadjikhln");
    got.delete();
    keys = 10'h000;
    wait_bytes(10, 100);
    tick(4);
    check_seq("rr_release", got, "WSADJIKHLN");
    got.delete();

    // p1_left pulse while p1_up's byte is stalled must vanish
    tx_if.tx_ready = 1'b0;
    keys           = 10'h001;
    wait_valid("glitch_valid");
    check_eq("glitch_data", 32'(tx_if.tx_data), 32'h77);
    keys = 10'h005;
    tick(3);
    keys = 10'h001;
    tick(6);
    tx_if.tx_ready = 1'b1;
    tick(10);
    check_seq("glitch", got, "w");
    got.delete();

    // Reset while 'd' is stalled; both held keys are re-reported afterwards
    tx_if.tx_ready = 1'b0;
    keys           = 10'h009;
    wait_valid("rst_valid");
    check_eq("rst_data", 32'(tx_if.tx_data), 32'h64);
    rst = 1'b1;
    tick(1);
    check_eq("rst_drop", 32'(tx_if.tx_valid), 32'd0);
    rst            = 1'b0;
    tx_if.tx_ready = 1'b1;
    wait_bytes(2, 40);
    tick(4);
    check_seq("rst_resend", got, "wd");
    got.delete();

    // Refresh: p2_right held, then released
    rst_r = 1'b1;
    tick(1);
    got_r.delete();
    got_r_cyc.delete();
    rst_r  = 1'b0;
    keys_r = 10'h100;
    tick(235);
    check_seq("refresh_held", got_r, "lNWSADJIKHlNWSADJIKHl");
    if (got_r_cyc.size() >= 21) begin
      check_eq("refresh_period_l", got_r_cyc[20] - got_r_cyc[10], 100);
      l_cyc = got_r_cyc[20];
    end else begin
      check_eq("refresh_period_l_cnt", got_r_cyc.size(), 21);
      l_cyc = 0;
    end
    got_r.delete();
    got_r_cyc.delete();
    keys_r = 10'h000;
    tick(100);
    check_seq("refresh_released", got_r, "LNWSADJIKHL");
    if (got_r_cyc.size() >= 11) begin
      check_eq("refresh_period_L", got_r_cyc[10] - l_cyc, 100);
    end else begin
      check_eq("refresh_period_L_cnt", got_r_cyc.size(), 11);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
